// File: rtl/video_wb_pkg.sv
// Shared types for the video-subsystem Wishbone masters and their arbiter.
package video_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hf;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        lock;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/video_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the frame
// store (m0) and the frame fetch (m1). A grant lasts for the whole bus cycle
// unless the holder has completed MAX_BEATS beats, is not locked, and the
// other master is waiting.
module video_wb_arbiter
  import video_wb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        nRST,
  // master 0: frame store
  input  logic        m0_wb_CYC_I,
  input  logic        m0_wb_STB_I,
  input  logic        m0_wb_LOCK_I,
  input  logic        m0_wb_WE_I,
  input  logic [3:0]  m0_wb_SEL_I,
  input  logic [31:0] m0_wb_ADR_I,
  input  logic [31:0] m0_wb_DAT_I,
  output logic [31:0] m0_wb_DAT_O,
  output logic        m0_wb_ACK_O,
  output logic        m0_wb_ERR_O,
  // master 1: frame fetch
  input  logic        m1_wb_CYC_I,
  input  logic        m1_wb_STB_I,
  input  logic        m1_wb_LOCK_I,
  input  logic        m1_wb_WE_I,
  input  logic [3:0]  m1_wb_SEL_I,
  input  logic [31:0] m1_wb_ADR_I,
  input  logic [31:0] m1_wb_DAT_I,
  output logic [31:0] m1_wb_DAT_O,
  output logic        m1_wb_ACK_O,
  output logic        m1_wb_ERR_O,
  // shared port towards the interconnect
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  output logic [1:0]  gnt
);

  localparam logic [7:0] LP_MAX_BEATS = 8'(MAX_BEATS);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [7:0] r_beat_cnt;

  wb_req_t    w_m0_req;
  wb_req_t    w_m1_req;
  wb_req_t    w_fwd;
  logic       w_beat;
  logic       w_cap;

  assign w_m0_req = '{cyc: m0_wb_CYC_I, stb: m0_wb_STB_I, lock: m0_wb_LOCK_I,
                      we: m0_wb_WE_I, sel: m0_wb_SEL_I, adr: m0_wb_ADR_I,
                      dat: m0_wb_DAT_I};
  assign w_m1_req = '{cyc: m1_wb_CYC_I, stb: m1_wb_STB_I, lock: m1_wb_LOCK_I,
                      we: m1_wb_WE_I, sel: m1_wb_SEL_I, adr: m1_wb_ADR_I,
                      dat: m1_wb_DAT_I};

  // A beat terminates whenever the forwarded strobe meets ACK or ERR.
  assign w_beat = w_fwd.stb & (p_wb_ACK_I | p_wb_ERR_I);
  // True when the beat terminating this cycle brings the tenure to MAX_BEATS.
  assign w_cap  = ({1'b0, r_beat_cnt} + 9'd1) >= {1'b0, LP_MAX_BEATS};

  // Mux the granted master onto the shared port; idle drives no cycle.
  always_comb begin
    w_fwd = w_m0_req;
    unique case (r_state)
      GNT0:    w_fwd = w_m0_req;
      GNT1:    w_fwd = w_m1_req;
      default: begin
        w_fwd.cyc  = 1'b0;
        w_fwd.stb  = 1'b0;
        w_fwd.lock = 1'b0;
        w_fwd.we   = 1'b0;
      end
    endcase
  end

  // Next-state and round-robin pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (m0_wb_CYC_I && m1_wb_CYC_I) w_state_nxt = r_last ? GNT0 : GNT1;
        else if (m0_wb_CYC_I)           w_state_nxt = GNT0;
        else if (m1_wb_CYC_I)           w_state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_wb_CYC_I ||
            (w_beat && w_cap && m1_wb_CYC_I && !m0_wb_LOCK_I)) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = m1_wb_CYC_I ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_wb_CYC_I ||
            (w_beat && w_cap && m0_wb_CYC_I && !m1_wb_LOCK_I)) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = m0_wb_CYC_I ? GNT0 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant state and round-robin pointer registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Beat counter: restarts with every new grant, saturates at MAX_BEATS.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_beat_cnt <= '0;
    end else if ((w_state_nxt != r_state) && (w_state_nxt != IDLE)) begin
      r_beat_cnt <= '0;
    end else if (w_beat && (r_beat_cnt < LP_MAX_BEATS)) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

  assign p_wb_CYC_O  = w_fwd.cyc;
  assign p_wb_STB_O  = w_fwd.stb;
  assign p_wb_LOCK_O = w_fwd.lock;
  assign p_wb_WE_O   = w_fwd.we;
  assign p_wb_SEL_O  = w_fwd.sel;
  assign p_wb_ADR_O  = w_fwd.adr;
  assign p_wb_DAT_O  = w_fwd.dat;

  assign gnt = {r_state == GNT1, r_state == GNT0};

  assign m0_wb_ACK_O = (r_state == GNT0) & p_wb_ACK_I;
  assign m0_wb_ERR_O = (r_state == GNT0) & p_wb_ERR_I;
  assign m1_wb_ACK_O = (r_state == GNT1) & p_wb_ACK_I;
  assign m1_wb_ERR_O = (r_state == GNT1) & p_wb_ERR_I;

  assign m0_wb_DAT_O = p_wb_DAT_I;
  assign m1_wb_DAT_O = p_wb_DAT_I;

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Bench for video_wb_arbiter: directed cycle tables, a mid-burst reset
// sequence and randomized traffic checked against a transaction-level model.
module tb_video_wb_arbiter;
  import video_wb_pkg::*;

  localparam int TB_MAX = 4;

  logic        clk;
  logic        nRST;
  logic [1:0]  cyc, stb, lock, we;
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat0, rdat1;
  logic        ack0, ack1, err0, err1;
  logic        p_cyc, p_stb, p_lock, p_we;
  logic [3:0]  p_sel;
  logic [31:0] p_adr, p_dato, p_dati;
  logic        p_ack, p_err;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_errors = 0;

  video_wb_arbiter #(.MAX_BEATS(TB_MAX)) dut (
    .clk(clk), .nRST(nRST),
    .m0_wb_CYC_I(cyc[0]), .m0_wb_STB_I(stb[0]), .m0_wb_LOCK_I(lock[0]),
    .m0_wb_WE_I(we[0]), .m0_wb_SEL_I(sel[0]), .m0_wb_ADR_I(adr[0]),
    .m0_wb_DAT_I(wdat[0]), .m0_wb_DAT_O(rdat0), .m0_wb_ACK_O(ack0),
    .m0_wb_ERR_O(err0),
    .m1_wb_CYC_I(cyc[1]), .m1_wb_STB_I(stb[1]), .m1_wb_LOCK_I(lock[1]),
    .m1_wb_WE_I(we[1]), .m1_wb_SEL_I(sel[1]), .m1_wb_ADR_I(adr[1]),
    .m1_wb_DAT_I(wdat[1]), .m1_wb_DAT_O(rdat1), .m1_wb_ACK_O(ack1),
    .m1_wb_ERR_O(err1),
    .p_wb_CYC_O(p_cyc), .p_wb_STB_O(p_stb), .p_wb_LOCK_O(p_lock),
    .p_wb_WE_O(p_we), .p_wb_SEL_O(p_sel), .p_wb_ADR_O(p_adr),
    .p_wb_DAT_O(p_dato), .p_wb_DAT_I(p_dati), .p_wb_ACK_I(p_ack),
    .p_wb_ERR_I(p_err), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner of the port (-1 = nobody), who was served last, and beats completed
  // in the current tenure (unbounded count, compared against MAX_BEATS).
  int m_owner  = -1;
  int m_last   = 1;
  int m_tenure = 0;

  task automatic model_check();
    int x;
    logic [1:0] eg;
    logic [3:0] ectl, eterm;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk("gnt", 64'(gnt), 64'(eg));
    ectl = '0;
    if (m_owner >= 0) begin
      x = m_owner;
      ectl = {cyc[x], stb[x], lock[x], we[x]};
      chk("sel", 64'(p_sel), 64'(sel[x]));
      chk("adr", 64'(p_adr), 64'(adr[x]));
      chk("wdat", 64'(p_dato), 64'(wdat[x]));
    end
    chk("ctl", 64'({p_cyc, p_stb, p_lock, p_we}), 64'(ectl));
    eterm = {(m_owner == 0) && p_ack, (m_owner == 1) && p_ack,
             (m_owner == 0) && p_err, (m_owner == 1) && p_err};
    chk("term", 64'({ack0, ack1, err0, err1}), 64'(eterm));
    chk("rdata", {rdat1, rdat0}, {p_dati, p_dati});
  endtask

  task automatic model_step();
    int x, o;
    bit beat;
    if (m_owner < 0) begin
      if (cyc[0] && cyc[1]) m_owner = (m_last == 1) ? 0 : 1;
      else if (cyc[0])      m_owner = 0;
      else if (cyc[1])      m_owner = 1;
      m_tenure = 0;
    end else begin
      x = m_owner;
      o = 1 - x;
      beat = stb[x] && (p_ack || p_err);
      if (beat) m_tenure++;
      if (!cyc[x] || (beat && m_tenure >= TB_MAX && cyc[o] && !lock[x])) begin
        m_last   = x;
        m_owner  = cyc[o] ? o : -1;
        m_tenure = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!nRST) begin
        m_owner  = -1;
        m_last   = 1;
        m_tenure = 0;
      end
      model_check();
      if (nRST) model_step();
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rb;
    bit          c0, s0, l0, c1, s1, l1, ak, er;
    logic [31:0] a0;
    logic [1:0]  eg;
    bit          epc, ea0, ea1, ee0, ee1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rb, c0, s0, l0, c1, s1, l1, ak, er,
                              input logic [31:0] a0, input logic [1:0] eg,
                              input bit epc, ea0, ea1, ee0, ee1);
    vec_t v;
    v.rb = rb; v.c0 = c0; v.s0 = s0; v.l0 = l0; v.c1 = c1; v.s1 = s1; v.l1 = l1;
    v.ak = ak; v.er = er; v.a0 = a0; v.eg = eg; v.epc = epc;
    v.ea0 = ea0; v.ea1 = ea1; v.ee0 = ee0; v.ee1 = ee1;
    return v;
  endfunction

  task automatic clr_inputs();
    cyc = '0; stb = '0; lock = '0; we = 2'b01;
    sel[0] = WB_SEL_ALL; sel[1] = WB_SEL_ALL;
    adr[0] = 32'h0; adr[1] = 32'h2000;
    wdat[0] = 32'hA5A5_0000; wdat[1] = 32'h5A5A_1111;
    p_ack = 1'b0; p_err = 1'b0; p_dati = 32'hCAFE_0000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    nRST = 1'b0;
    clr_inputs();
    @(posedge clk); #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    clr_inputs();

    // single requester, 4 beats; ACK in the CYC-drop cycle is still forwarded
    tbl.push_back(mk(1, 1,1,0, 0,0,0, 0,0, 32'h1000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h1000, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h1004, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h1008, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h100C, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h100C, 2'b01,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0,    2'b00,0, 0,0,0,0));
    // simultaneous start, gapless handover, alternating contests
    tbl.push_back(mk(1, 1,1,0, 1,1,0, 0,0, 32'h1000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h1000, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 0,0, 32'h1000, 2'b01,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 1,0, 32'h1000, 2'b10,1, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h1000, 2'b10,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 0,0, 32'h1000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h1000, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h1000, 2'b01,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 0,0, 32'h1000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 0,0, 32'h1000, 2'b10,1, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h1000, 2'b10,0, 0,0,0,0));
    // preemption after MAX_BEATS=4; m0 stalls while m1 is served
    tbl.push_back(mk(1, 1,1,0, 0,0,0, 0,0, 32'h3000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h3000, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h3004, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h3008, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h300C, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 1,0, 32'h3010, 2'b10,1, 0,1,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 0,0, 32'h3010, 2'b10,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h3010, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h3014, 2'b01,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0,    2'b00,0, 0,0,0,0));
    // LOCK: 10 beats uninterrupted although m1 waits from beat 2
    tbl.push_back(mk(1, 1,1,1, 0,0,0, 0,0, 32'h4000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,1, 0,0,0, 1,0, 32'h4000, 2'b01,1, 1,0,0,0));
    for (int i = 1; i < 10; i++)
      tbl.push_back(mk(0, 1,1,1, 1,1,0, 1,0, 32'h4000 + 32'(4 * i), 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 0,0, 32'h4028, 2'b01,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 1,0, 32'h4028, 2'b10,1, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h4028, 2'b10,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0,    2'b00,0, 0,0,0,0));
    // ERR routed only to m1, then m1 abandons an un-acked strobe
    tbl.push_back(mk(1, 0,0,0, 1,1,0, 0,0, 32'h5000, 2'b00,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 1,0, 32'h5000, 2'b10,1, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0, 1,1,0, 0,1, 32'h5000, 2'b10,1, 0,0,0,1));
    tbl.push_back(mk(0, 1,1,0, 1,1,0, 0,0, 32'h5000, 2'b10,1, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 0,0, 32'h5000, 2'b10,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h5000, 2'b01,1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h5000, 2'b01,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0,    2'b00,0, 0,0,0,0));

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      @(posedge clk); #1;
      cyc    = {tbl[i].c1, tbl[i].c0};
      stb    = {tbl[i].s1, tbl[i].s0};
      lock   = {tbl[i].l1, tbl[i].l0};
      adr[0] = tbl[i].a0;
      p_ack  = tbl[i].ak;
      p_err  = tbl[i].er;
      p_dati = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({gnt, p_cyc, ack0, ack1, err0, err1}),
          64'({tbl[i].eg, tbl[i].epc, tbl[i].ea0, tbl[i].ea1, tbl[i].ee0, tbl[i].ee1}));
    end

    // reset in the middle of an m1 burst: outputs drop without a clock edge
    do_reset();
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    p_ack = 1'b1;
    #2;
    chk("pre_rst_gnt", 64'(gnt), 64'(2'b10));
    nRST = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'(2'b00));
    chk("rst_ctl", 64'({p_cyc, p_stb, p_lock, p_we}), 64'(4'b0000));
    chk("rst_term", 64'({ack0, ack1, err0, err1}), 64'(4'b0000));
    @(posedge clk); #1;
    nRST = 1'b1;
    p_ack = 1'b0;
    cyc = 2'b11; stb = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_contest", 64'(gnt), 64'(2'b01));
    @(posedge clk); #1;
    clr_inputs();

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(0, 7) == 0)  cyc[x]  = ~cyc[x];
        stb[x] = cyc[x] && ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 15) == 0) lock[x] = ~lock[x];
        we[x]   = 1'($urandom_range(0, 1));
        sel[x]  = ($urandom_range(0, 1) == 0) ? WB_SEL_ALL : 4'($urandom);
        adr[x]  = $urandom;
        wdat[x] = $urandom;
      end
      p_ack  = ($urandom_range(0, 9) < 6);
      p_err  = !p_ack && ($urandom_range(0, 19) == 0);
      p_dati = $urandom;
    end

    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
